tlb_pipe: RTL and testbench

- Parametrised, registered-lookup successor of the MIPS R1 joint TLB, with one instruction and one data translation port.
- Adds a per-entry valid bit cleared at reset, an internal Wired/Random pair and a handshaked management-op FSM (TLBP/TLBR/TLBWI/TLBWR) with a done pulse.
- Lookups take exactly 1 cycle, which eases the timing of the fetch and memory stages.
- Sits between the pipeline address stages and CP0; CP0 owns EntryHi, EntryLo0/1, PageMask and Index.

---
 rtl/tlb_pipe.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_tlb_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tlb_pipe.sv
// Joint TLB with registered single-cycle lookups on an instruction and a data port,
// a TLBP/TLBR/TLBWI/TLBWR management FSM and internal Wired/Random registers.
module tlb_pipe #(
    parameter int unsigned TLB_LINE  = 32,
    parameter int unsigned TLB_WIDTH = $clog2(TLB_LINE),
    parameter int unsigned ASID_W    = 8
) (
    input  logic                 clk,
    input  logic                 resetn,

    input  logic                 inst_req,
    input  logic [31:0]          inst_vaddr,
    output logic                 inst_rsp,
    output logic [31:0]          inst_paddr,
    output logic                 inst_found,
    output logic                 inst_V_flag,
    output logic                 inst_uncached,

    input  logic                 data_req,
    input  logic [31:0]          data_vaddr,
    output logic                 data_rsp,
    output logic [31:0]          data_paddr,
    output logic                 data_found,
    output logic                 data_V_flag,
    output logic                 data_D_flag,
    output logic                 data_uncached,

    input  logic                 op_valid,
    input  logic [2:0]           op_type,
    output logic                 op_ready,
    output logic                 op_done,

    input  logic [31:0]          EntryHi_in,
    input  logic [31:0]          PageMask_in,
    input  logic [31:0]          EntryLo0_in,
    input  logic [31:0]          EntryLo1_in,
    input  logic [31:0]          Index_in,
    input  logic                 wired_we,
    input  logic [TLB_WIDTH-1:0] wired_in,

    output logic [31:0]          EntryHi_out,
    output logic [31:0]          PageMask_out,
    output logic [31:0]          EntryLo0_out,
    output logic [31:0]          EntryLo1_out,
    output logic [31:0]          Index_out,
    output logic [TLB_WIDTH-1:0] Random_out
);

    localparam logic [TLB_WIDTH-1:0] LastIdx = TLB_WIDTH'(TLB_LINE - 1);
    localparam logic [2:0] OpTlbp  = 3'd1;
    localparam logic [2:0] OpTlbr  = 3'd2;
    localparam logic [2:0] OpTlbwi = 3'd3;
    localparam logic [2:0] OpTlbwr = 3'd4;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

    typedef struct packed {
        logic        found;
        logic        v;
        logic        d;
        logic        unc;
        logic [31:0] paddr;
    } lookup_t;

    // Lo fields kept as EntryLo[25:1]: {PFN, C, D, V}; G is held per entry
    logic [18:0]         e_vpn2 [TLB_LINE];
    logic [ASID_W-1:0]   e_asid [TLB_LINE];
    logic [15:0]         e_mask [TLB_LINE];
    logic [24:0]         e_lo0  [TLB_LINE];
    logic [24:0]         e_lo1  [TLB_LINE];
    logic [TLB_LINE-1:0] e_g;
    logic [TLB_LINE-1:0] valid_q;

    state_t              state_q, state_d;
    logic [2:0]          op_type_q;
    logic [31:0]         hi_q, pm_q, lo0_q, lo1_q, idx_q;
    logic [TLB_WIDTH-1:0] rnd_q, random_q, wired_q;

    logic                accept, exec, wr_en;
    logic [TLB_WIDTH-1:0] wr_idx, rd_idx;
    logic [TLB_WIDTH:0]  probe_res;
    lookup_t             inst_lk, data_lk;
    logic                unused_bits;

    function automatic logic entry_match(input int i, input logic [18:0] vpn2,
                                         input logic [ASID_W-1:0] asid);
        logic [18:0] m;
        m = {3'b000, e_mask[i]};
        return valid_q[i] && (e_g[i] || (e_asid[i] == asid)) &&
               ((e_vpn2[i] & ~m) == (vpn2 & ~m));
    endfunction

    // Scans downwards so the lowest matching index is the one left standing
    function automatic logic [TLB_WIDTH:0] probe(input logic [18:0] vpn2,
                                                 input logic [ASID_W-1:0] asid);
        logic [TLB_WIDTH:0] r;
        r = '0;
        for (int i = TLB_LINE - 1; i >= 0; i--) begin
            if (entry_match(i, vpn2, asid)) r = {1'b1, TLB_WIDTH'(i)};
        end
        return r;
    endfunction

    function automatic lookup_t lookup(input logic [31:0] va, input logic [ASID_W-1:0] asid);
        lookup_t            r;
        logic [TLB_WIDTH:0] hit;
        logic [24:0]        lo;
        logic [19:0]        m;
        r   = '0;
        hit = '0;
        lo  = '0;
        m   = '0;
        if (va[31:30] == 2'b10) begin
            r.found = 1'b1;
            r.v     = 1'b1;
            r.d     = 1'b1;
            r.unc   = (va[31:29] == 3'b101);
            r.paddr = {3'b000, va[28:0]};
        end else begin
            hit = probe(va[31:13], asid);
            if (hit[TLB_WIDTH]) begin
                lo      = va[12] ? e_lo1[hit[TLB_WIDTH-1:0]] : e_lo0[hit[TLB_WIDTH-1:0]];
                m       = {3'b000, e_mask[hit[TLB_WIDTH-1:0]], 1'b0};
                r.found = 1'b1;
                r.v     = lo[0];
                r.d     = lo[1];
                r.unc   = (lo[4:2] == 3'd2);
                r.paddr = {(lo[24:5] & ~m) | (va[31:12] & m), va[11:0]};
            end
        end
        return r;
    endfunction

    // Lookups

    always_comb begin
        inst_lk = lookup(inst_vaddr, EntryHi_in[ASID_W-1:0]);
        data_lk = lookup(data_vaddr, EntryHi_in[ASID_W-1:0]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rsp      <= 1'b0;
            inst_paddr    <= '0;
            inst_found    <= 1'b0;
            inst_V_flag   <= 1'b0;
            inst_uncached <= 1'b0;
            data_rsp      <= 1'b0;
            data_paddr    <= '0;
            data_found    <= 1'b0;
            data_V_flag   <= 1'b0;
            data_D_flag   <= 1'b0;
            data_uncached <= 1'b0;
        end else begin
            inst_rsp <= inst_req;
            data_rsp <= data_req;
            if (inst_req) begin
                inst_paddr    <= inst_lk.paddr;
                inst_found    <= inst_lk.found;
                inst_V_flag   <= inst_lk.v;
                inst_uncached <= inst_lk.unc;
            end
            if (data_req) begin
                data_paddr    <= data_lk.paddr;
                data_found    <= data_lk.found;
                data_V_flag   <= data_lk.v;
                data_D_flag   <= data_lk.d;
                data_uncached <= data_lk.unc;
            end
        end
    end

    // Management FSM

    assign op_ready = (state_q == StIdle);
    assign op_done  = (state_q == StDone);
    assign accept   = op_valid && op_ready;
    assign exec     = (state_q == StExec);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (op_valid) state_d = StExec;
            StExec:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            op_type_q <= '0;
            hi_q      <= '0;
            pm_q      <= '0;
            lo0_q     <= '0;
            lo1_q     <= '0;
            idx_q     <= '0;
            rnd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_type_q <= op_type;
                hi_q      <= EntryHi_in;
                pm_q      <= PageMask_in & 32'h1FFF_E000;
                lo0_q     <= EntryLo0_in;
                lo1_q     <= EntryLo1_in;
                idx_q     <= Index_in;
                rnd_q     <= random_q;
            end
        end
    end

    assign wr_en  = exec && (((op_type_q == OpTlbwi) && !idx_q[TLB_WIDTH]) ||
                             (op_type_q == OpTlbwr));
    assign wr_idx = (op_type_q == OpTlbwr) ? rnd_q : idx_q[TLB_WIDTH-1:0];
    assign rd_idx = idx_q[TLB_WIDTH-1:0];

    always_comb probe_res = probe(hi_q[31:13], hi_q[ASID_W-1:0]);

    // Entry contents carry no reset; valid_q alone gates their use
    always_ff @(posedge clk) begin
        if (wr_en) begin
            e_vpn2[wr_idx] <= hi_q[31:13] & ~{3'b000, pm_q[28:13]};
            e_asid[wr_idx] <= hi_q[ASID_W-1:0];
            e_mask[wr_idx] <= pm_q[28:13];
            e_lo0[wr_idx]  <= lo0_q[25:1];
            e_lo1[wr_idx]  <= lo1_q[25:1];
            e_g[wr_idx]    <= lo0_q[0] & lo1_q[0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            EntryHi_out  <= '0;
            PageMask_out <= '0;
            EntryLo0_out <= '0;
            EntryLo1_out <= '0;
            Index_out    <= '0;
        end else if (exec) begin
            case (op_type_q)
                OpTlbp: begin
                    Index_out <= probe_res[TLB_WIDTH] ? 32'(probe_res[TLB_WIDTH-1:0])
                                                      : 32'h8000_0000;
                end
                OpTlbr: begin
                    if (valid_q[rd_idx]) begin
                        EntryHi_out  <= {e_vpn2[rd_idx], 13'b0} | 32'(e_asid[rd_idx]);
                        PageMask_out <= {3'b000, e_mask[rd_idx], 13'b0};
                        EntryLo0_out <= {6'b0, e_lo0[rd_idx], e_g[rd_idx]};
                        EntryLo1_out <= {6'b0, e_lo1[rd_idx], e_g[rd_idx]};
                    end else begin
                        EntryHi_out  <= '0;
                        PageMask_out <= '0;
                        EntryLo0_out <= '0;
                        EntryLo1_out <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Wired / Random

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_q <= LastIdx;
            wired_q  <= '0;
        end else if (wired_we) begin
            wired_q  <= wired_in;
            random_q <= LastIdx;
        end else if (exec && (op_type_q == OpTlbwr)) begin
            random_q <= random_q;
        end else if ((wired_q >= LastIdx) || (random_q <= wired_q)) begin
            random_q <= LastIdx;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    assign Random_out = random_q;

    assign unused_bits = ^{hi_q[12:ASID_W], pm_q[31:29], pm_q[12:0], lo0_q[31:26],
                           lo1_q[31:26], idx_q[31:TLB_WIDTH+1]};

endmodule

// File: tb/tb_tlb_pipe.sv
// Directed self-checking bench for tlb_pipe: lookups, management ops, Random/Wired,
// write/lookup ordering and reset during an op.
module tb_tlb_pipe;

    logic        clk;
    logic        resetn;
    logic        inst_req, data_req;
    logic [31:0] inst_vaddr, data_vaddr;
    logic        inst_rsp, inst_found, inst_V_flag, inst_uncached;
    logic [31:0] inst_paddr;
    logic        data_rsp, data_found, data_V_flag, data_D_flag, data_uncached;
    logic [31:0] data_paddr;
    logic        op_valid;
    logic [2:0]  op_type;
    logic        op_ready, op_done;
    logic [31:0] EntryHi_in, PageMask_in, EntryLo0_in, EntryLo1_in, Index_in;
    logic        wired_we;
    logic [4:0]  wired_in;
    logic [31:0] EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out;
    logic [4:0]  Random_out;

    int n_assert = 0;
    int n_fail   = 0;

    tlb_pipe dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_rsp(inst_rsp),
        .inst_paddr(inst_paddr), .inst_found(inst_found), .inst_V_flag(inst_V_flag),
        .inst_uncached(inst_uncached),
        .data_req(data_req), .data_vaddr(data_vaddr), .data_rsp(data_rsp),
        .data_paddr(data_paddr), .data_found(data_found), .data_V_flag(data_V_flag),
        .data_D_flag(data_D_flag), .data_uncached(data_uncached),
        .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready), .op_done(op_done),
        .EntryHi_in(EntryHi_in), .PageMask_in(PageMask_in), .EntryLo0_in(EntryLo0_in),
        .EntryLo1_in(EntryLo1_in), .Index_in(Index_in),
        .wired_we(wired_we), .wired_in(wired_in),
        .EntryHi_out(EntryHi_out), .PageMask_out(PageMask_out),
        .EntryLo0_out(EntryLo0_out), .EntryLo1_out(EntryLo1_out),
        .Index_out(Index_out), .Random_out(Random_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] va, input logic [7:0] asid,
                          input logic f, input logic v, input logic d, input logic u,
                          input logic [31:0] pa);
        inst_req   = 1'b1;
        data_req   = 1'b1;
        inst_vaddr = va;
        data_vaddr = va;
        EntryHi_in = {24'h0, asid};
        tick();
        inst_req = 1'b0;
        data_req = 1'b0;
        check({tag, "_irsp"}, inst_rsp, 1);
        check({tag, "_drsp"}, data_rsp, 1);
        check({tag, "_ifound"}, inst_found, f);
        check({tag, "_dfound"}, data_found, f);
        check({tag, "_ipaddr"}, inst_paddr, pa);
        check({tag, "_dpaddr"}, data_paddr, pa);
        check({tag, "_iv"}, inst_V_flag, v);
        check({tag, "_dv"}, data_V_flag, v);
        check({tag, "_dd"}, data_D_flag, d);
        check({tag, "_iunc"}, inst_uncached, u);
        check({tag, "_dunc"}, data_uncached, u);
    endtask

    task automatic op(input string tag, input logic [2:0] t, input logic [31:0] idx,
                      input logic [31:0] hi, input logic [31:0] pm,
                      input logic [31:0] lo0, input logic [31:0] lo1);
        op_type     = t;
        Index_in    = idx;
        EntryHi_in  = hi;
        PageMask_in = pm;
        EntryLo0_in = lo0;
        EntryLo1_in = lo1;
        op_valid    = 1'b1;
        tick();
        op_valid = 1'b0;
        check({tag, "_busy"}, op_ready, 0);
        check({tag, "_early"}, op_done, 0);
        tick();
        check({tag, "_done"}, op_done, 1);
        tick();
        check({tag, "_done_clr"}, op_done, 0);
        check({tag, "_ready"}, op_ready, 1);
    endtask

    task automatic readback(input string tag, input logic [31:0] hi, input logic [31:0] pm,
                            input logic [31:0] lo0, input logic [31:0] lo1);
        check({tag, "_hi"}, EntryHi_out, hi);
        check({tag, "_pm"}, PageMask_out, pm);
        check({tag, "_lo0"}, EntryLo0_out, lo0);
        check({tag, "_lo1"}, EntryLo1_out, lo1);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; data_req = 1'b0; inst_vaddr = '0; data_vaddr = '0;
        op_valid = 1'b0; op_type = '0;
        EntryHi_in = '0; PageMask_in = '0; EntryLo0_in = '0; EntryLo1_in = '0; Index_in = '0;
        wired_we = 1'b0; wired_in = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        check("rst_ready", op_ready, 1);
        check("rst_done", op_done, 0);
        check("rst_irsp", inst_rsp, 0);
        check("rst_drsp", data_rsp, 0);
        check("rst_random", Random_out, 31);
        check("rst_index", Index_out, 0);
        check("rst_dpaddr", data_paddr, 0);
        readback("rst", 0, 0, 0, 0);

        lookup("miss_empty", 32'h0040_1000, 8'd0, 0, 0, 0, 0, 32'h0);
        tick();
        check("rsp_drop", data_rsp, 0);
        op("tlbr5", 3'd2, 32'd5, 0, 0, 0, 0);
        readback("tlbr5", 0, 0, 0, 0);

        op("wi3", 3'd3, 32'd3, 32'h0040_0005, 32'h0, 32'h0000_1016, 32'h0000_105E);
        lookup("hit_even", 32'h0040_0ABC, 8'd5, 1, 1, 1, 1, 32'h0004_0ABC);
        lookup("hit_odd", 32'h0040_1ABC, 8'd5, 1, 1, 1, 0, 32'h0004_1ABC);
        lookup("asid_even", 32'h0040_0ABC, 8'd6, 0, 0, 0, 0, 32'h0);
        lookup("asid_odd", 32'h0040_1ABC, 8'd6, 0, 0, 0, 0, 32'h0);
        op("tlbr3", 3'd2, 32'd3, 0, 0, 0, 0);
        readback("tlbr3", 32'h0040_0005, 0, 32'h0000_1016, 32'h0000_105E);

        op("tlbp_hit", 3'd1, 0, 32'h0040_0005, 0, 0, 0);
        check("tlbp_hit_idx", Index_out, 32'h3);
        op("tlbp_miss", 3'd1, 0, 32'h0080_0005, 0, 0, 0);
        check("tlbp_miss_idx", Index_out, 32'h8000_0000);

        // Index bit 5 set: write suppressed, entry 0 stays invalid
        op("wi_probefail", 3'd3, 32'h20, 32'h0040_0005, 0, 32'h0000_7016, 32'h0000_105E);
        lookup("pf_keep", 32'h0040_0ABC, 8'd5, 1, 1, 1, 1, 32'h0004_0ABC);
        op("tlbr0", 3'd2, 32'd0, 0, 0, 0, 0);
        readback("tlbr0", 0, 0, 0, 0);

        op("wi7", 3'd3, 32'd7, 32'h0200_0000, 32'hE000_6FFF, 32'h0000_4006, 32'h0000_4046);
        lookup("big_even", 32'h0200_2ABC, 8'd0, 1, 1, 1, 0, 32'h0010_2ABC);
        lookup("big_odd", 32'h0200_7ABC, 8'd0, 1, 1, 1, 0, 32'h0010_7ABC);
        op("tlbr7", 3'd2, 32'd7, 0, 0, 0, 0);
        readback("tlbr7", 32'h0200_0000, 32'h0000_6000, 32'h0000_4006, 32'h0000_4046);

        lookup("kseg0", 32'h8000_1234, 8'd0, 1, 1, 1, 0, 32'h0000_1234);
        lookup("kseg1", 32'hA000_1234, 8'd0, 1, 1, 1, 1, 32'h0000_1234);

        wired_we = 1'b1;
        wired_in = 5'd28;
        tick();
        wired_we = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("random_%0d", k), Random_out, 32'(31 - (k % 4)));
            if (k != 10) tick();
        end
        for (int k = 0; k < 8 && Random_out != 5'd29; k++) tick();
        check("random_at_wr", Random_out, 29);
        op("wr", 3'd4, 0, 32'h0100_0007, 0, 32'h0000_3017, 32'h0000_305F);
        op("tlbr29", 3'd2, 32'd29, 0, 0, 0, 0);
        readback("tlbr29", 32'h0100_0007, 0, 32'h0000_3017, 32'h0000_305F);
        lookup("global", 32'h0100_1234, 8'd9, 1, 1, 1, 0, 32'h000C_1234);

        // Lookup sampled in the EXEC cycle sees the old entry, the next one the new entry
        op_type = 3'd3; Index_in = 32'd3; EntryHi_in = 32'h0040_0005; PageMask_in = 0;
        EntryLo0_in = 32'h0000_2016; EntryLo1_in = 32'h0000_105E;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        data_req = 1'b1; data_vaddr = 32'h0040_0ABC; EntryHi_in = 32'h5;
        tick();
        check("haz_done", op_done, 1);
        check("haz_old", data_paddr, 32'h0004_0ABC);
        tick();
        data_req = 1'b0;
        check("haz_new", data_paddr, 32'h0008_0ABC);
        check("haz_new_rsp", data_rsp, 1);
        tick();

        op_type = 3'd3; Index_in = 32'd3; EntryHi_in = 32'h0040_0005;
        EntryLo0_in = 32'h0000_3016; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        check("rst_op_busy", op_ready, 0);
        resetn = 1'b0;
        #1;
        check("rst_op_ready", op_ready, 1);
        check("rst_op_nodone", op_done, 0);
        tick();
        check("rst_op_nodone2", op_done, 0);
        resetn = 1'b1;
        tick();
        check("rst_op_nodone3", op_done, 0);
        check("rst_op_ready2", op_ready, 1);
        lookup("rst_miss3", 32'h0040_0ABC, 8'd5, 0, 0, 0, 0, 32'h0);
        lookup("rst_miss29", 32'h0100_1234, 8'd9, 0, 0, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
